// File: rtl/theia_pixel_sink.sv
// Pixel write-back sink for the THEIA core. It accepts Wishbone pixel writes into a small FIFO and
// drains them to framebuffer memory, counting committed pixels toward frame completion.
module theia_pixel_sink #(
   parameter int unsigned     WB_W         = 32,
   parameter int unsigned     FIFO_AW      = 3,
   parameter logic [WB_W-1:0] FB_BASE      = 32'h0000_0000,
   parameter logic [15:0]     FRAME_PIXELS = 16'd1024
) (
   input  logic               CLK_I,
   input  logic               RST_I,
   // slave port, driven by the core's master port
   input  logic               S_CYC_I,
   input  logic               S_STB_I,
   input  logic               S_WE_I,
   input  logic [WB_W-1:0]    S_ADR_I,
   input  logic [WB_W-1:0]    S_DAT_I,
   output logic [WB_W-1:0]    S_DAT_O,
   output logic               S_ACK_O,
   // master port to framebuffer memory
   output logic               M_CYC_O,
   output logic               M_STB_O,
   output logic               M_WE_O,
   output logic [WB_W-1:0]    M_ADR_O,
   output logic [WB_W-1:0]    M_DAT_O,
   input  logic               M_ACK_I,
   // frame status
   input  logic               FRAME_CLR_I,
   output logic               FRAME_DONE_O,
   output logic [15:0]        PIXEL_COUNT_O,
   output logic [FIFO_AW:0]   FIFO_LEVEL_O
);

   localparam int unsigned      DEPTH    = 1 << FIFO_AW;
   localparam logic [FIFO_AW:0] FULL_LVL = (FIFO_AW + 1)'(DEPTH);

   typedef enum logic {
      ST_IDLE,
      ST_WRITE
   } state_e;

   state_e                  state_q, state_d;
   logic                    cyc_q, cyc_d;
   logic [WB_W-1:0]         adr_q, adr_d;
   logic [WB_W-1:0]         dat_q, dat_d;
   logic                    ack_q;
   logic [WB_W-1:0]         sdat_q;
   logic [2*WB_W-1:0]       mem_q [DEPTH];
   logic [FIFO_AW-1:0]      wr_ptr_q, rd_ptr_q;
   logic [FIFO_AW:0]        level_q;
   logic [15:0]             count_q, count_d;
   logic                    done_q, done_d;
   logic                    full, empty, push, rd_req, pop;
   logic [2*WB_W-1:0]       head;

   // full/empty come from the pre-edge level, so a pop in the same cycle never frees room for a push
   assign full   = (level_q == FULL_LVL);
   assign empty  = (level_q == '0);
   assign push   = S_CYC_I & S_STB_I &  S_WE_I & ~ack_q & ~full;
   assign rd_req = S_CYC_I & S_STB_I & ~S_WE_I & ~ack_q;
   assign head   = mem_q[rd_ptr_q];

   always_ff @(posedge CLK_I) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (RST_I) begin
         ack_q  <= 1'b0;
         sdat_q <= '0;
      end else begin
         ack_q <= push | rd_req;
         if (rd_req) sdat_q <= {{(WB_W - 16){1'b0}}, count_q};
      end
   end

   // NOTE: storage has no reset; the pointers and level alone define which entries are valid.
   always_ff @(posedge CLK_I) begin
      if (push) mem_q[wr_ptr_q] <= {S_ADR_I, S_DAT_I};
   end

   always_ff @(posedge CLK_I) begin
      if (RST_I) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         case ({push, pop})
            2'b10:   level_q <= level_q + 1'b1;
            2'b01:   level_q <= level_q - 1'b1;
            default: level_q <= level_q;
         endcase
      end
   end

   always_comb begin
      // NOTE: every combinational output gets a default first so no latch is inferred.
      state_d = state_q;
      cyc_d   = cyc_q;
      adr_d   = adr_q;
      dat_d   = dat_q;
      pop     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (!empty) begin
               pop     = 1'b1;
               adr_d   = FB_BASE + head[2*WB_W-1:WB_W];
               dat_d   = head[WB_W-1:0];
               cyc_d   = 1'b1;
               state_d = ST_WRITE;
            end
         end
         ST_WRITE: begin
            if (M_ACK_I) begin
               cyc_d   = 1'b0;
               state_d = ST_IDLE;
            end
         end
         default: begin
            cyc_d   = 1'b0;
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK_I) begin
      if (RST_I) begin
         state_q <= ST_IDLE;
         cyc_q   <= 1'b0;
         adr_q   <= '0;
         dat_q   <= '0;
      end else begin
         state_q <= state_d;
         cyc_q   <= cyc_d;
         adr_q   <= adr_d;
         dat_q   <= dat_d;
      end
   end

   // A clear wins over a coinciding ack; the count saturates once the frame is complete.
   always_comb begin
      count_d = count_q;
      done_d  = done_q;
      if (FRAME_CLR_I) begin
         count_d = '0;
         done_d  = 1'b0;
      end else if ((state_q == ST_WRITE) && M_ACK_I && (count_q != FRAME_PIXELS)) begin
         count_d = count_q + 16'd1;
         if (count_q + 16'd1 == FRAME_PIXELS) done_d = 1'b1;
      end
   end

   always_ff @(posedge CLK_I) begin
      if (RST_I) begin
         count_q <= '0;
         done_q  <= 1'b0;
      end else begin
         count_q <= count_d;
         done_q  <= done_d;
      end
   end

   assign S_ACK_O       = ack_q;
   assign S_DAT_O       = sdat_q;
   assign M_CYC_O       = cyc_q;
   assign M_STB_O       = cyc_q;
   assign M_WE_O        = cyc_q;
   assign M_ADR_O       = adr_q;
   assign M_DAT_O       = dat_q;
   assign FRAME_DONE_O  = done_q;
   assign PIXEL_COUNT_O = count_q;
   assign FIFO_LEVEL_O  = level_q;

endmodule
